// File: rtl/strobe_gen.sv
// Programmable single-cycle strobe generator: emits a burst of one-cycle
// strobes spaced by a latched period, with a delayed copy and run status.
module strobe_gen #(
    parameter int PERIOD_WIDTH = 8,
    parameter int COUNT_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic [COUNT_WIDTH-1:0]  burst,
    output logic                    strobe,
    output logic                    strobe_q,
    output logic                    busy,
    output logic                    done,
    output logic [COUNT_WIDTH-1:0]  strobe_count
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0]  COUNT_ONE  = COUNT_WIDTH'(1);

    state_t                  state;
    logic [PERIOD_WIDTH-1:0] period_lat;
    logic [COUNT_WIDTH-1:0]  burst_lat;
    logic [PERIOD_WIDTH-1:0] phase;
    logic [PERIOD_WIDTH-1:0] period_eff;

    assign period_eff = (period == '0) ? PERIOD_ONE : period;

    // phase holds the number of edges left before the next strobe is due;
    // it reloads with period-1 so a strobe lands every period_lat clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            period_lat   <= '0;
            burst_lat    <= '0;
            phase        <= '0;
            strobe       <= 1'b0;
            strobe_q     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            strobe_count <= '0;
        end else begin
            strobe_q <= strobe;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    strobe <= 1'b0;
                    if (start && !stop) begin
                        state        <= RUN;
                        period_lat   <= period_eff;
                        burst_lat    <= burst;
                        phase        <= period_eff - PERIOD_ONE;
                        strobe       <= 1'b1;
                        busy         <= 1'b1;
                        strobe_count <= COUNT_ONE;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state  <= IDLE;
                        strobe <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (burst_lat != '0 && strobe_count == burst_lat) begin
                        // Count reaches the burst on the last strobe; end one edge later.
                        state  <= IDLE;
                        strobe <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else if (phase == '0) begin
                        strobe       <= 1'b1;
                        phase        <= period_lat - PERIOD_ONE;
                        strobe_count <= strobe_count + COUNT_ONE;
                    end else begin
                        strobe <= 1'b0;
                        phase  <= phase - PERIOD_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    strobe <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/strobe_gen.md
# strobe_gen

Programmable single-cycle strobe generator: the producing end of the strobe interface consumed by the design's strobe counters. On `start` it latches a period and a burst length, then emits one-cycle `strobe` pulses every `period` clocks until the burst completes or `stop` is asserted. It also provides a one-cycle-delayed copy `strobe_q` for consumers that sample a registered strobe, plus `busy`/`done` status and a running count of strobes emitted.

## Interface

Parameters:
- `PERIOD_WIDTH`, 8: width of `period`; the maximum period is 2^PERIOD_WIDTH-1.
- `COUNT_WIDTH`, 4: width of `burst` and `strobe_count`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `stop`  in  1  abort the current run; sampled only in RUN.
- `period`  in  PERIOD_WIDTH  clocks between strobes; 0 is treated as 1.
- `burst`  in  COUNT_WIDTH  number of strobes; 0 means continuous until `stop`.
- `strobe`  out  1  one-cycle strobe, registered.
- `strobe_q`  out  1  `strobe` delayed by one clock.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a run ends, whether completed or aborted.
- `strobe_count`  out  COUNT_WIDTH  number of strobes emitted in the current or last run.

## Operation

- **States:** IDLE and RUN.
- **Reset:** `reset_n` low immediately forces IDLE. All outputs go to 0, and the latched period, latched burst and internal counters go to 0. Reset may be asserted in any state; no `done` pulse is produced.
- **IDLE -> RUN:** on an edge with `start`=1 and `stop`=0.
  - `period` and `burst` are latched; a period of 0 is latched as 1.
  - `strobe_count` is cleared to 0, then immediately incremented for the first strobe (see Timing).
- **RUN:**
  - A phase counter reloads on every strobe; `strobe` asserts once every latched-period clocks.
  - `strobe_count` increments, wrapping modulo 2^COUNT_WIDTH, on the same edge that raises `strobe`.
  - Changes to the `period` and `burst` inputs during RUN are ignored.
- **RUN -> IDLE (complete):** when `burst` != 0, on the edge after the strobe that makes `strobe_count` equal the latched burst.
- **RUN -> IDLE (abort):** on any edge with `stop`=1.
  - No further strobes are emitted, including one otherwise due on that edge.
  - `strobe_count` holds its value.
- **Priority:** `stop` beats `start` in every state.
  - `start`+`stop` in IDLE starts nothing.
  - `start` during RUN is ignored and the run is not restarted.
- **Continuous mode** (`burst`=0): runs until `stop`. `strobe_count` wraps freely, e.g. 15 -> 0 with COUNT_WIDTH=4.
- `strobe_q` is unconditional: it is `strobe` from the previous cycle, even across the RUN -> IDLE transition.

## Timing

- Let E0 be the edge that samples the accepted `start`, and P the latched period (P ≥ 1).
- **Strobes:** `strobe` is high in the cycle following edges E0, E0+P, E0+2P, …
  - Latency from `start` to the first strobe is 1 clock.
  - With P=1, `strobe` is continuously high for the length of the burst.
- **Burst completion** (B = latched burst, B ≥ 1):
  - The last strobe follows edge E0+(B-1)P.
  - At edge E0+(B-1)P+1: `done`=1 for exactly one cycle, `busy`=0, `strobe`=0.
  - `strobe_q` for the last strobe coincides with `done`.
- **Busy window:** `busy` rises on edge E0 and falls on the same edge that raises `done`.
- **Abort:** a `stop` sampled at edge Es gives `busy`=0, `done`=1 and `strobe`=0 after Es.
- **Restart:** a new `start` is accepted on the edge after `done` at the earliest, i.e. the first edge seen in IDLE.

## Test plan

- **Reset mid-run:** run with P=3, B=0, drop `reset_n` asynchronously between edges -> all outputs 0 immediately; after release the block stays idle with no strobes until `start`.
- **Programmed burst:** P=3, B=4, `start` at E0 -> `strobe` after E0, E0+3, E0+6 and E0+9, with `strobe_count` 1, 2, 3, 4; `strobe_q` one cycle later each; `done`=1 and `busy`=0 after E0+10.
- **Back-to-back strobes:** P=0, B=3 -> `strobe` high for 3 consecutive cycles after E0; `done` after E0+3; repeating with P=1 gives an identical trace.
- **Continuous mode and abort:** P=2, B=0, run 40 cycles -> `strobe_count` wraps 15 -> 0. Then assert `stop` on an edge where a strobe is due -> that strobe is suppressed, `done` pulses once, and `strobe_count` holds.
- **Ignored requests:**
  - `start` pulsed while busy -> no restart and no change to timing or count.
  - `start`+`stop` together in IDLE -> remains idle with no `done`.
  - `period` changed mid-run -> strobe spacing unchanged.
- **Immediate restart:** assert `start` on the first edge after `done` -> accepted, and the new run's first strobe appears 1 clock later with `strobe_count`=1.
